// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
// -----------------------------------------------------------------------------
// Memory-mapped UART transmitter. It sits between the processor data-memory
// port and the data RAM.
//   * A store to TX_ADDR pushes dataIn[7:0] into a TX FIFO of 2**FIFO_AW bytes.
//   * A load from STATUS_ADDR returns {29'b0, overflow, full, empty}.
//   * A store to STATUS_ADDR clears the sticky overflow flag.
//   * Every other address passes straight through to the RAM.
// A serializer drains the FIFO onto uart_tx, least significant bit first.
//
// Frame format:
//   * Default: 8N1, 10 bit-times.
//   * With the macro UART_TX_PARITY_EN defined: an even-parity bit is sent
//     between the data bits and the stop bit, giving 11 bit-times.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit
//   FIFO_AW       FIFO address width (depth = 2**FIFO_AW)
//   TX_ADDR       write-only transmit register address
//   STATUS_ADDR   status read / overflow clear address
//
// Ports
//   clock    in   1   system clock, all state on posedge
//   reset    in   1   asynchronous, active-high
//   wren     in   1   processor store strobe
//   addr     in  12   processor data address
//   dataIn   in  32   processor store data
//   ram_q    in  32   RAM read data (valid the cycle after addr)
//   ram_wEn  out  1   RAM write enable (never asserted at the MMIO addresses)
//   q_dmem   out 32   read data returned to the processor (1-cycle latency)
//   uart_tx  out  1   serial line, idle high
//   tx_busy  out  1   high while the FIFO holds data or a frame is in flight
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_AW      = 4,
   parameter logic [11:0] TX_ADDR      = 12'hFF0,
   parameter logic [11:0] STATUS_ADDR  = 12'hFF1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wren,
   input  logic [11:0] addr,
   input  logic [31:0] dataIn,
   input  logic [31:0] ram_q,
   output logic        ram_wEn,
   output logic [31:0] q_dmem,
   output logic        uart_tx,
   output logic        tx_busy
);

   // --------------------------------------------------------------------------
   // Derived constants
   // --------------------------------------------------------------------------
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]   BAUD_ONE  = CNT_W'(1);
   localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [2:0]         BIT_LAST  = 3'd7;

   // --------------------------------------------------------------------------
   // Serializer states
   // --------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;
`endif

   // --------------------------------------------------------------------------
   // Address decode
   // --------------------------------------------------------------------------
   logic hit_tx;
   logic hit_status;

   assign hit_tx     = (addr == TX_ADDR);
   assign hit_status = (addr == STATUS_ADDR);

   // The RAM must never see a store aimed at one of the MMIO registers.
   assign ram_wEn    = wren & ~hit_tx & ~hit_status;

   // Only the low byte of a transmit store is meaningful.
   logic unused_data_hi;
   assign unused_data_hi = ^dataIn[31:8];

   // --------------------------------------------------------------------------
   // TX FIFO
   // --------------------------------------------------------------------------
   // Pointers carry one extra wrap bit, so full and empty can be told apart
   // without a separate occupancy counter.
   logic [7:0]       fifo_mem [0:DEPTH-1];
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]       fifo_rd_data;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push_req;
   logic             push_ok;
   logic             pop;
   logic             ovf_event;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

   assign push_req   = wren & hit_tx;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is
   // still accepted in that case.
   assign push_ok    = push_req & (~fifo_full | pop);
   assign ovf_event  = push_req & fifo_full & ~pop;

   // The head entry is read combinationally so that a pop completes in one
   // cycle. When a full FIFO is pushed and popped together, the write slot
   // equals the read slot. The read still returns the old head, because the
   // write only lands at the clock edge.
   assign fifo_rd_data = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];

   always_ff @(posedge clock) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= dataIn[7:0];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // --------------------------------------------------------------------------
   // Sticky overflow flag
   // --------------------------------------------------------------------------
   logic overflow_q, overflow_d;

   // A fresh overflow in the same cycle as a clear store keeps the flag set.
   // Losing that event would hide a dropped byte from software.
   always_comb begin
      overflow_d = overflow_q;
      if (ovf_event) begin
         overflow_d = 1'b1;
      end else if (wren && hit_status) begin
         overflow_d = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Read path
   // --------------------------------------------------------------------------
   // The status word is captured in the same cycle as the address, so it
   // appears one cycle later, exactly like synchronous RAM data.
   logic       sel_status_q, sel_status_d;
   logic [2:0] status_q, status_d;

   always_comb begin
      sel_status_d = hit_status;
      status_d     = status_q;
      if (hit_status) begin
         status_d = {overflow_q, fifo_full, fifo_empty};
      end
   end

   assign q_dmem = sel_status_q ? {29'b0, status_q} : ram_q;

   // --------------------------------------------------------------------------
   // Serializer
   // --------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             baud_tick;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign baud_tick = (baud_q == BAUD_LAST);

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            baud_d    = '0;
            bit_idx_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
               parity_d = ^fifo_rd_data;
`endif
               state_d = S_START;
            end
         end

         S_START: begin
            if (baud_tick) begin
               baud_d  = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end

         S_DATA: begin
            if (baud_tick) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == BIT_LAST) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = S_PARITY;
`else
                  state_d   = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_tick) begin
               baud_d  = '0;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
`endif

         S_STOP: begin
            if (baud_tick) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end

         default: begin
            baud_d    = '0;
            bit_idx_d = '0;
            state_d   = S_IDLE;
         end
      endcase

      // The line level is derived from the next state and registered.
      // uart_tx therefore switches on the same edge as the state and stays
      // glitch-free.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   assign uart_tx = tx_q;
   assign tx_busy = ~fifo_empty | (state_q != S_IDLE);

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   // sel_status resets high with a zero snapshot, so q_dmem reads zero out of
   // reset rather than whatever the RAM happens to present.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         sel_status_q <= 1'b1;
         status_q     <= '0;
         state_q      <= S_IDLE;
         baud_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         sel_status_q <= sel_status_d;
         status_q     <= status_d;
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
// -----------------------------------------------------------------------------
// Scoreboard bench for mmio_uart_tx with CLKS_PER_BIT = 4.
//   * Stimulus issues stores and loads, and queues the expected results:
//       - serial frames go into tx_exp;
//       - load data goes into rd_exp.
//   * A UART monitor samples every bit-cycle of each frame and pops tx_exp.
//   * A read monitor checks q_dmem one cycle after each load and pops rd_exp.
//   * A small RAM model supplies ram_q with a one-cycle read latency.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   localparam logic [11:0] A_TX  = 12'hFF0;
   localparam logic [11:0] A_ST  = 12'hFF1;

   logic        clock = 1'b0;
   logic        reset;
   logic        wren;
   logic [11:0] addr;
   logic [31:0] dataIn;
   logic [31:0] ram_q;
   logic        ram_wEn;
   logic [31:0] q_dmem;
   logic        uart_tx;
   logic        tx_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] b;
      bit         b2b;
   } tx_exp_t;

   typedef struct {
      logic [11:0] a;
      logic [31:0] d;
   } rd_exp_t;

   tx_exp_t tx_exp[$];
   rd_exp_t rd_exp[$];

   logic rd_strobe;
   logic rd_pipe = 1'b0;
   int   wen_cnt = 0;

   logic [31:0] ram_mem [0:4095];

   always #5 clock = ~clock;

   mmio_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_AW     (4),
      .TX_ADDR     (A_TX),
      .STATUS_ADDR (A_ST)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .wren   (wren),
      .addr   (addr),
      .dataIn (dataIn),
      .ram_q  (ram_q),
      .ram_wEn(ram_wEn),
      .q_dmem (q_dmem),
      .uart_tx(uart_tx),
      .tx_busy(tx_busy)
   );

   // Synchronous-read RAM model.
   always @(posedge clock) begin
      if (ram_wEn) ram_mem[addr] <= dataIn;
      ram_q <= ram_mem[addr];
   end

   always @(negedge clock) begin
      if (ram_wEn) wen_cnt <= wen_cnt + 1;
   end

   // --------------------------------------------------------------------------
   // Helpers
   // --------------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Expected per-cycle line levels of a frame, one bit per clock cycle.
   function automatic logic [63:0] frame_vec(input logic [7:0] b);
      logic [63:0] v;
      int          slot;
      v = '0;
      for (int k = 0; k < FRAME_CYC; k++) begin
         slot = k / CPB;
         if (slot == 0)            v[k] = 1'b0;
         else if (slot <= 8)       v[k] = b[slot-1];
         else if (slot == NBITS-1) v[k] = 1'b1;
         else                      v[k] = ^b;
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic store(input logic [11:0] a, input logic [31:0] d);
      wren   = 1'b1;
      addr   = a;
      dataIn = d;
      tick();
      wren   = 1'b0;
      addr   = 12'h000;
      dataIn = 32'h0;
   endtask

   task automatic send(input logic [7:0] b, input bit b2b, input logic [23:0] hi);
      tx_exp_t e;
      e.b   = b;
      e.b2b = b2b;
      tx_exp.push_back(e);
      store(A_TX, {hi, b});
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] d);
      rd_exp_t e;
      e.a = a;
      e.d = d;
      rd_exp.push_back(e);
      addr      = a;
      rd_strobe = 1'b1;
      tick();
      rd_strobe = 1'b0;
      addr      = 12'h000;
   endtask

   task automatic wait_idle(input string name, input int limit, output int busy_cycles);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (!tx_busy) begin
            done = 1'b1;
            break;
         end
         n++;
      end
      busy_cycles = n;
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_timeout: tx_busy still 1 after %0d cycles, required 0", name, limit);
      end
      @(posedge clock);
      #1;
   endtask

   // --------------------------------------------------------------------------
   // Read monitor: q_dmem is checked one cycle after each load address
   // --------------------------------------------------------------------------
   always @(posedge clock) rd_pipe <= rd_strobe;

   initial begin : rd_mon
      rd_exp_t e;
      forever begin
         @(negedge clock);
         if (rd_pipe) begin
            if (rd_exp.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL rd_unexpected: got q_dmem %h required no read", q_dmem);
            end else begin
               e = rd_exp.pop_front();
               check($sformatf("rd_%03h", e.a), q_dmem, e.d);
               $display("[rd] addr=%03h q_dmem=%08h expected=%08h", e.a, q_dmem, e.d);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // UART monitor: records every cycle of a frame, checks start-to-start gaps
   // --------------------------------------------------------------------------
   initial begin : uart_mon
      int          cyc;
      int          start_cyc;
      int          last_start;
      bit          aborted;
      logic [63:0] got;
      tx_exp_t     e;
      cyc        = 0;
      last_start = -1000;
      forever begin
         @(negedge clock);
         cyc++;
         if (!reset && uart_tx == 1'b0) begin
            start_cyc = cyc;
            got       = '0;
            aborted   = 1'b0;
            e.b       = 8'h00;
            e.b2b     = 1'b0;
            if (tx_exp.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL tx_unexpected: got start bit at cycle %0d required none", cyc);
            end else begin
               e = tx_exp.pop_front();
            end
            for (int k = 1; k < FRAME_CYC; k++) begin
               @(negedge clock);
               cyc++;
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
               got[k] = uart_tx;
            end
            if (aborted) begin
               $display("[tx] frame %02h aborted by reset", e.b);
               last_start = -1000;
            end else begin
               check($sformatf("tx_frame_%02h", e.b), got, frame_vec(e.b));
               if (e.b2b) begin
                  check($sformatf("tx_gap_%02h", e.b), 64'(start_cyc - last_start), 64'(FRAME_CYC + 1));
               end
               $display("[tx] byte=%02h line=%011h start_cycle=%0d", e.b, got, start_cyc);
               last_start = start_cyc;
            end
         end
      end
   end

   // Global safety net against a hung run.
   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin : stim
      int bc;
      for (int i = 0; i < 4096; i++) ram_mem[i] = 32'h0;
      ram_mem[12'h020] = 32'hCAFEF00D;
      reset     = 1'b1;
      wren      = 1'b0;
      addr      = 12'h000;
      dataIn    = 32'h0;
      rd_strobe = 1'b0;

      // Reset state.
      repeat (3) @(posedge clock);
      #1;
      check("rst_uart_tx", uart_tx, 1);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_q_dmem", q_dmem, 0);
      check("rst_ram_wEn", ram_wEn, 0);
      #3 reset = 1'b0;
      tick();
      rd(A_ST, 32'h1);

      // Single byte 0xA5: exact frame, busy span, no RAM write.
      send(8'hA5, 1'b0, 24'h000000);
      check("a5_no_ram_write", wen_cnt, 0);
      wait_idle("a5", 200, bc);
      check("a5_busy_cycles", bc, 1 + FRAME_CYC);
      repeat (2) tick();

      // Overflow:
      //   * 0x11 occupies the serializer;
      //   * 17 back-to-back stores follow, and the 17th is dropped.
      send(8'h11, 1'b0, 24'hABCDEF);
      repeat (3) tick();
      for (int i = 0; i < 17; i++) begin
         if (i < 16) begin
            send(8'(8'h20 + i), 1'b1, 24'h5A5A5A);
         end else begin
            store(A_TX, {24'h5A5A5A, 8'(8'h20 + i)});
         end
      end
      rd(A_ST, 32'h6);
      store(A_ST, 32'h0);
      rd(A_ST, 32'h2);

      // Land a push on the very cycle the serializer pops the next byte.
      // The FIFO is full, yet the push must be accepted without overflow.
      repeat (FRAME_CYC - 22) tick();
      send(8'hC3, 1'b1, 24'h000000);
      rd(A_ST, 32'h2);
      check("mmio_no_ram_write", wen_cnt, 0);
      wait_idle("burst", 2000, bc);
      rd(A_ST, 32'h1);

      // RAM pass-through.
      store(12'h010, 32'h12345678);
      check("ram_wEn_once", wen_cnt, 1);
      rd(12'h010, 32'h12345678);
      rd(12'h020, 32'hCAFEF00D);
      store(A_ST, 32'hFFFFFFFF);
      check("status_store_no_ram", wen_cnt, 1);

      // Reset during data bit 3 of 0x52, with two more bytes queued.
      send(8'h52, 1'b0, 24'h000000);
      send(8'h66, 1'b1, 24'h000000);
      send(8'h77, 1'b1, 24'h000000);
      repeat (16) tick();
      check("pre_rst_uart_tx", uart_tx, 0);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_uart_tx", uart_tx, 1);
      check("mid_rst_tx_busy", tx_busy, 0);
      tx_exp.delete();
      @(posedge clock);
      #3 reset = 1'b0;
      tick();
      rd(A_ST, 32'h1);
      send(8'h3C, 1'b0, 24'h000000);
      wait_idle("post_rst", 200, bc);
      check("post_rst_busy_cycles", bc, 1 + FRAME_CYC);

`ifdef UART_TX_PARITY_EN
      // 0x07 has three set bits, so the even-parity bit is 1.
      repeat (2) tick();
      send(8'h07, 1'b0, 24'h000000);
      wait_idle("parity", 200, bc);
      check("parity_busy_cycles", bc, 1 + FRAME_CYC);
`endif

      repeat (5) tick();
      check("tx_queue_drained", tx_exp.size(), 0);
      check("rd_queue_drained", rd_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
